// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate-bank sweep controller.
// Holds the op_sel encodings, the FSM state enum, the sweep result payload,
// the MISR seed/taps and the MISR step helper. The helper is only used when
// GATE_SWEEP_SIG_EN is defined.
package gate_sweep_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned RESP_W  = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ERR_W   = 4;
    localparam int unsigned SIG_W   = 8;

    // Expected-function selector. Encodings 5..7 are illegal.
    typedef enum logic [OP_W-1:0] {
        OP_OR   = 3'd0,
        OP_XOR  = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XNOR = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Sweep result reported to the host.
    typedef struct packed {
        logic             pass;
        logic [ERR_W-1:0] err_cnt;
        logic [IDX_W-1:0] first_fail;
    } result_t;

    localparam logic [SIG_W-1:0] MISR_SEED = 8'hFF;
    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [SIG_W-1:0] MISR_TAPS = 8'hB8;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_XNOR;
    endfunction

    // Shift left, feed back the tap parity into bit 0, then fold in resp.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [RESP_W-1:0] r);
        return {s[SIG_W-2:0], ^(s & MISR_TAPS)} ^ SIG_W'(r);
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Host/gate-bank signal bundle of the sweep controller.
// master: controller side (drives vectors and results, receives start,
//         op_sel and the gate-bank response).
// slave:  environment side (host plus gate bank).
// sig is present only when GATE_SWEEP_SIG_EN is defined.
interface gate_sweep_ctrl_if;
    import gate_sweep_pkg::*;

    logic                start;
    logic [OP_W-1:0]     op_sel;
    logic [RESP_W-1:0]   resp;
    logic                vec_a;
    logic                vec_b;
    logic                vec_c;
    logic                busy;
    logic                done;
    logic                pass;
    logic [ERR_W-1:0]    err_cnt;
    logic [IDX_W-1:0]    first_fail;
`ifdef GATE_SWEEP_SIG_EN
    logic [SIG_W-1:0]    sig;
`endif

    modport master (
`ifdef GATE_SWEEP_SIG_EN
        output sig,
`endif
        input  start, op_sel, resp,
        output vec_a, vec_b, vec_c, busy, done, pass, err_cnt, first_fail
    );

    modport slave (
`ifdef GATE_SWEEP_SIG_EN
        input  sig,
`endif
        output start, op_sel, resp,
        input  vec_a, vec_b, vec_c, busy, done, pass, err_cnt, first_fail
    );

endinterface

// File: rtl/gate_sweep_ctrl_ref_model.sv
// gate_ref_model: combinational expected output of the gate bank.
// Ports: i_op (function select), i_a/i_b/i_c (vector bits, a = MSB of idx),
//        o_exp_c (expected final output d; 0 for illegal selects).
module gate_ref_model
    import gate_sweep_pkg::*;
(
    input  op_e  i_op,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_exp_c
);

    always_comb begin : p_expected
        o_exp_c = 1'b0;
        case (i_op)
            OP_OR:   o_exp_c =   i_a | i_b | i_c;
            OP_XOR:  o_exp_c =   i_a ^ i_b ^ i_c;
            OP_NAND: o_exp_c = ~(i_a & i_b & i_c);
            OP_NOR:  o_exp_c = ~(i_a | i_b | i_c);
            OP_XNOR: o_exp_c = ~(i_a ^ i_b ^ i_c);
            default: o_exp_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: self-test sequencer for a 3-input gate bank.
// Drives the 8 input vectors in ascending order, holds each for DWELL cycles
// plus one sample cycle, compares resp[0] with the expected function and
// reports pass, mismatch count and first failing vector.
// Ports: clk, rst_n (synchronous, active low), bus (gate_sweep_ctrl_if.master:
//        start/op_sel/resp in; vec_a/b/c, busy, done, pass, err_cnt,
//        first_fail out; sig out when GATE_SWEEP_SIG_EN is defined).
// Parameter: DWELL, hold cycles per vector before sampling, 1..255.
// Option: GATE_SWEEP_SIG_EN adds an 8-bit MISR signature over resp[2:0].
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    gate_sweep_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_ALL    = ERR_W'(NUM_VEC);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    op_e              r_op;
    op_e              w_op_nxt;
    result_t          r_res;
    result_t          w_res_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [IDX_W-1:0] r_vec;
    logic [IDX_W-1:0] w_vec_nxt;
    logic             w_start_ok;
    logic             w_exp;
    logic             w_mismatch;
`ifdef GATE_SWEEP_SIG_EN
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_nxt;
`else
    // Intermediates only feed the signature.
    logic             w_unused_resp;
    assign w_unused_resp = ^bus.resp[2:1];
`endif

    gate_ref_model u_ref_model (
        .i_op    (r_op),
        .i_a     (r_idx[2]),
        .i_b     (r_idx[1]),
        .i_c     (r_idx[0]),
        .o_exp_c (w_exp)
    );

    assign w_start_ok = op_is_legal(bus.op_sel);
    assign w_mismatch = (r_state == ST_SAMPLE) && (bus.resp[0] != w_exp);

    // State register.
    always_ff @(posedge clk) begin : p_state_reg
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_start_ok ? ST_DRIVE : ST_DONE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_state_nxt = (r_idx == LAST_IDX) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin : p_outputs
        w_idx_nxt = r_idx;
        w_cnt_nxt = r_cnt;
        w_op_nxt  = r_op;
        w_res_nxt = r_res;
`ifdef GATE_SWEEP_SIG_EN
        w_sig_nxt = r_sig;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef GATE_SWEEP_SIG_EN
                    w_sig_nxt = MISR_SEED;
`endif
                    w_res_nxt.pass       = 1'b0;
                    w_res_nxt.first_fail = '0;
                    if (w_start_ok) begin
                        w_op_nxt          = op_e'(bus.op_sel);
                        w_idx_nxt         = '0;
                        w_cnt_nxt         = DWELL_LOAD;
                        w_res_nxt.err_cnt = '0;
                    end else begin
                        // Illegal select: report every vector as failing.
                        w_res_nxt.err_cnt = ERR_ALL;
                    end
                end
            end
            ST_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    if (r_res.err_cnt == '0) begin
                        w_res_nxt.first_fail = r_idx;
                    end
                    w_res_nxt.err_cnt = r_res.err_cnt + ERR_W'(1);
                end
`ifdef GATE_SWEEP_SIG_EN
                w_sig_nxt = misr_step(r_sig, bus.resp);
`endif
                if (r_idx != LAST_IDX) begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                    w_cnt_nxt = DWELL_LOAD;
                end
            end
            ST_DONE: begin
                w_idx_nxt = '0;
            end
            default: begin
                w_idx_nxt = '0;
            end
        endcase

        // Verdict is registered on entry to DONE so it is valid with done.
        if (w_state_nxt == ST_DONE) begin
            w_res_nxt.pass = (w_res_nxt.err_cnt == '0);
        end

        w_busy_nxt = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_vec_nxt  = w_busy_nxt ? w_idx_nxt : '0;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin : p_regs
        if (!rst_n) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_op   <= OP_OR;
            r_res  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_vec  <= '0;
`ifdef GATE_SWEEP_SIG_EN
            r_sig  <= MISR_SEED;
`endif
        end else begin
            r_idx  <= w_idx_nxt;
            r_cnt  <= w_cnt_nxt;
            r_op   <= w_op_nxt;
            r_res  <= w_res_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_vec  <= w_vec_nxt;
`ifdef GATE_SWEEP_SIG_EN
            r_sig  <= w_sig_nxt;
`endif
        end
    end

    assign bus.vec_a      = r_vec[2];
    assign bus.vec_b      = r_vec[1];
    assign bus.vec_c      = r_vec[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_res.pass;
    assign bus.err_cnt    = r_res.err_cnt;
    assign bus.first_fail = r_res.first_fail;
`ifdef GATE_SWEEP_SIG_EN
    assign bus.sig        = r_sig;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl. Two instances: DWELL=4 for the
// single-sweep scenarios and DWELL=1 for back-to-back sweeps under held start.
// The gate bank is modelled as a per-vector response table; expected results
// come from the truth-table patterns of each function.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    localparam int unsigned DW0 = 4;
    localparam int unsigned DW1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    gate_sweep_ctrl_if if0 ();
    gate_sweep_ctrl_if if1 ();

    gate_sweep_ctrl #(.DWELL(DW0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    gate_sweep_ctrl #(.DWELL(DW1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

    // Gate-bank models: d table (bit i = resp[0] at idx i), intermediates packed 2 bits per idx.
    logic [7:0]  d0, d1;
    logic [15:0] m0, m1;
    logic [2:0]  vi0, vi1;

    assign vi0 = {if0.vec_a, if0.vec_b, if0.vec_c};
    assign vi1 = {if1.vec_a, if1.vec_b, if1.vec_c};
    assign if0.resp = {m0[{vi0, 1'b0} +: 2], d0[vi0]};
    assign if1.resp = {m1[{vi1, 1'b0} +: 2], d1[vi1]};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Truth table of each function, bit i = output for idx i.
    function automatic logic [7:0] exp_pattern(input logic [2:0] op);
        case (op)
            3'd0:    return 8'hFE;
            3'd1:    return 8'h96;
            3'd2:    return 8'h7F;
            3'd3:    return 8'h01;
            3'd4:    return 8'h69;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] misr_model(input logic [7:0] d, input logic [15:0] m);
        logic [7:0] s;
        logic       fb;
        s = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            fb = s[7] ^ s[5] ^ s[4] ^ s[3];
            s  = {s[6:0], fb} ^ {5'b0, m[2*i +: 2], d[i]};
        end
        return s;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_busy"}, if0.busy, 0);
        check_eq({tag, "_done"}, if0.done, 0);
        check_eq({tag, "_pass"}, if0.pass, 0);
        check_eq({tag, "_err"}, if0.err_cnt, 0);
        check_eq({tag, "_ff"}, if0.first_fail, 0);
        check_eq({tag, "_vec"}, vi0, 0);
`ifdef GATE_SWEEP_SIG_EN
        check_eq({tag, "_sig"}, if0.sig, 8'hFF);
`endif
    endtask

    // One sweep on DUT0 with the current d0/m0 tables; op_sel and start are
    // scrambled while busy to confirm they are ignored.
    task automatic run_sweep(input string tag, input logic [2:0] op);
        logic       legal;
        logic       got;
        logic [7:0] diff;
        int         e_err, e_ff, exp_n, n, tr_bad;
        legal = (op <= 3'd4);
        diff  = d0 ^ exp_pattern(op);
        e_err = legal ? $countones(diff) : 8;
        e_ff  = 0;
        if (legal) for (int i = 7; i >= 0; i--) if (diff[i]) e_ff = i;
        exp_n = legal ? 1 + 8 * (DW0 + 1) : 1;

        @(negedge clk);
        if0.start  = 1'b1;
        if0.op_sel = op;
        @(posedge clk);
        n = 0; got = 1'b0; tr_bad = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (if0.done) got = 1'b1;
            else if (if0.busy !== 1'b1 || vi0 !== 3'((n - 1) / (DW0 + 1))) tr_bad++;
            if0.start  = got ? 1'b0 : 1'($urandom_range(0, 1));
            if0.op_sel = 3'($urandom_range(0, 7));
        end
        check_eq({tag, "_done_cycle"}, n, exp_n);
        check_eq({tag, "_trace"}, tr_bad, 0);
        check_eq({tag, "_err"}, if0.err_cnt, e_err);
        check_eq({tag, "_ff"}, if0.first_fail, e_ff);
        check_eq({tag, "_pass"}, if0.pass, (legal && diff == 8'h00) ? 1 : 0);
        check_eq({tag, "_vec_end"}, vi0, 0);
        check_eq({tag, "_busy_end"}, if0.busy, 0);
`ifdef GATE_SWEEP_SIG_EN
        check_eq({tag, "_sig"}, if0.sig, legal ? misr_model(d0, m0) : 8'hFF);
`endif
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, if0.done, 0);
        check_eq({tag, "_pass_hold"}, if0.pass, (legal && diff == 8'h00) ? 1 : 0);
        check_eq({tag, "_err_hold"}, if0.err_cnt, e_err);
    endtask

    initial begin
        int         n, pulses, last, rst_done;
        logic       found;
        logic [2:0] op;
        logic [7:0] flips;

        rst_n = 1'b0;
        if0.start = 1'b0; if0.op_sel = '0;
        if1.start = 1'b0; if1.op_sel = '0;
        d0 = '0; m0 = '0; d1 = '0; m1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Ideal OR, XOR stuck at 0, NAND realised as AND.
        d0 = exp_pattern(3'd0); m0 = 16'($urandom);
        run_sweep("or_ideal", 3'd0);
        d0 = 8'h00;
        run_sweep("xor_stuck0", 3'd1);
        d0 = 8'h80; m0 = 16'($urandom);
        run_sweep("nand_as_and", 3'd2);

        // Reset while vector 3 is being driven.
        d0 = 8'h00;
        @(negedge clk);
        if0.start = 1'b1; if0.op_sel = 3'd1;
        @(posedge clk);
        n = 0; found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if0.start = 1'b0;
            if (vi0 == 3'd3 && if0.busy) found = 1'b1;
        end
        check_eq("rst_idx3_cycle", n, 1 + 3 * (DW0 + 1));
        check_eq("rst_pre_err", if0.err_cnt, 2);
        check_eq("rst_pre_ff", if0.first_fail, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_reset");
        rst_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) rst_n = 1'b1;
            @(negedge clk);
            if (if0.done) rst_done++;
        end
        check_eq("rst_no_done", rst_done, 0);
        d0 = exp_pattern(3'd0); m0 = 16'($urandom);
        run_sweep("post_rst_or", 3'd0);

        // Illegal select.
        run_sweep("illegal6", 3'd6);

        // Randomized functions and fault tables.
        for (int it = 0; it < 8; it++) begin
            op    = 3'($urandom_range(0, 7));
            flips = 8'($urandom & $urandom & $urandom);
            if (it % 3 == 0) flips = 8'h00;
            d0 = exp_pattern(op) ^ flips;
            m0 = 16'($urandom);
            run_sweep("rand", op);
        end

        // Held start on DUT1: back-to-back NOR sweeps.
        d1 = exp_pattern(3'd3); m1 = 16'($urandom);
        @(negedge clk);
        if1.start = 1'b1; if1.op_sel = 3'd3;
        @(posedge clk);
        n = 0; pulses = 0; last = 0;
        while (pulses < 4 && n < 300) begin
            @(negedge clk);
            n++;
            if (if1.done) begin
                pulses++;
                if (pulses == 1) check_eq("held_first_done", n, 1 + 8 * (DW1 + 1));
                else check_eq("held_period", n - last, 8 * (DW1 + 1) + 2);
                check_eq("held_err", if1.err_cnt, 0);
                check_eq("held_pass", if1.pass, 1);
                check_eq("held_ff", if1.first_fail, 0);
`ifdef GATE_SWEEP_SIG_EN
                check_eq("held_sig", if1.sig, misr_model(d1, m1));
`endif
                last = n;
            end
        end
        check_eq("held_pulses", pulses, 4);
        if1.start = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
